wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural state sink at the far end of the write-back stage.
- Consumes the write-back bundle (destination address, write enable, data, HI/LO values, HI/LO enable) registered out of the MEM/WB pipeline register.
- Commits the bundle into a 32-entry general-purpose register file and the HI/LO special registers.
- Serves two GPR read ports plus HI/LO reads to decode/execute, with write-to-read bypass so a same-cycle commit is visible immediately.

Parameters:
- DATA_W, 32, width of GPRs, HI, LO.
- ADDR_W, 5, GPR address width.
- NREG, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wb_wreg  input  1  GPR write enable from write-back.
- wb_wd  input  ADDR_W  GPR write address.
- wb_wdata  input  DATA_W  GPR write data.
- wb_whilo  input  1  HI/LO write enable.
- wb_hi  input  DATA_W  HI write data.
- wb_lo  input  DATA_W  LO write data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data (combinational).
- hi_o  output  DATA_W  current HI, bypassed (combinational).
- lo_o  output  DATA_W  current LO, bypassed (combinational).

Behaviour:
- Reset:
  - Synchronous, active-high. On any rising edge with rst=1, all NREG GPRs, HI and LO clear to 0.
  - All write inputs are ignored on that edge.
  - While rst=1, rdata1, rdata2, hi_o and lo_o are forced to 0.
- GPR write:
  - On a rising edge with rst=0, wb_wreg=1 and wb_wd!=0, the entry at wb_wd takes wb_wdata.
  - Committed value is visible from storage starting the next cycle.
- Register 0:
  - Hardwired zero; writes to address 0 are silently discarded.
  - This is required: the upstream register resets with write enable asserted and address 0, and that must not corrupt state.
- HI/LO write:
  - On a rising edge with rst=0 and wb_whilo=1, HI takes wb_hi and LO takes wb_lo, both together.
  - There is no partial HI-only or LO-only write.
- GPR read port n (evaluated in priority order):
  1. rst=1 -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0.
  4. wb_wreg=1 and wb_wd==raddr_n -> wb_wdata (write-first bypass, zero latency).
  5. Otherwise -> stored entry.
- Both read ports are independent. Both may address the same register, and both may bypass in the same cycle.
- HI/LO read:
  - rst=1 -> 0.
  - wb_whilo=1 -> wb_hi / wb_lo (bypass).
  - Otherwise -> stored HI / LO.
- Simultaneous GPR write and HI/LO write in one cycle are independent; both commit.
- Read-during-write to a different address returns the stored value of the read address, unaffected by the write.
- Reset mid-operation:
  - A write presented on the same edge as rst=1 is lost.
  - After rst deasserts, every register reads 0 until rewritten.
- No X propagation: reads of never-written registers return 0, because reset is required before use.

Test Plan:
- Reset with wb_wreg=1, wb_wd=0, wb_wdata=0xFFFFFFFF -> after release, reg0 reads 0, all regs read 0, hi_o=lo_o=0.
- Write reg5=0x12345678 on cycle N; read raddr1=5 on cycle N -> rdata1=0x12345678 via bypass. Read on cycle N+1 with wb_wreg=0 -> 0x12345678 from storage.
- Write reg0=0xDEADBEEF, read raddr1=raddr2=0 in the same and next cycle -> rdata1=rdata2=0 in both.
- Write reg7=0xA on cycle N, then reg7=0xB on N+1 while re1=re2=1, raddr1=raddr2=7 -> N+1 outputs 0xB (bypass beats stored 0xA). Port 2 with re2=0 -> 0.
- wb_whilo=1, wb_hi=0x1, wb_lo=0x2, plus wb_wreg=1 writing reg31=0x3 in the same cycle -> hi_o=0x1, lo_o=0x2 same cycle; next cycle with enables low, hi_o=0x1, lo_o=0x2, reg31=0x3.
- Write reg9=0x55 and commit; assert rst for one cycle while presenting a write reg9=0x66 -> after release, reg9 reads 0 (neither 0x55 nor 0x66 retained).

Source files
------------

// File: rtl/wb_regfile_if.sv
// Write-back to register-file bundle plus read ports.
// master: write-back stage / decode side, which drives the commit bundle and read requests.
// slave : the register file, which returns read data and bypassed HI/LO.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file at the end of write-back: 32 GPRs (r0 hardwired
// to zero) plus HI/LO, with write-first bypass on every read path.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset; clears all state, forces reads to 0
//   bus - wb_regfile_if.slave: commit bundle in, two GPR read ports and HI/LO out
// NREG must equal 2**ADDR_W.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Next-state: r0 writes are dropped so the upstream reset bundle is harmless.
  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (bus.wb_wreg && (bus.wb_wd != '0)) begin
      gpr_d[bus.wb_wd] = bus.wb_wdata;
    end
    if (bus.wb_whilo) begin
      hi_d = bus.wb_hi;
      lo_d = bus.wb_lo;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Read port 1: reset, disable and r0 all yield zero; a same-cycle commit wins over storage.
  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (bus.wb_wreg && (bus.wb_wd == bus.raddr1)) begin
        bus.rdata1 = bus.wb_wdata;
      end else begin
        bus.rdata1 = gpr_q[bus.raddr1];
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (bus.wb_wreg && (bus.wb_wd == bus.raddr2)) begin
        bus.rdata2 = bus.wb_wdata;
      end else begin
        bus.rdata2 = gpr_q[bus.raddr2];
      end
    end
  end

  // HI/LO read with bypass of a same-cycle commit.
  always_comb begin
    bus.hi_o = '0;
    bus.lo_o = '0;
    if (!rst) begin
      bus.hi_o = bus.wb_whilo ? bus.wb_hi : hi_q;
      bus.lo_o = bus.wb_whilo ? bus.wb_lo : lo_q;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural contents as defined by the commit rules.
  logic [31:0] ref_gpr [32];
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'h0;
    if (bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
    return ref_gpr[a];
  endfunction

  task automatic drv(input logic r, input logic w, input logic [4:0] wd, input logic [31:0] wdata,
                     input logic hl, input logic [31:0] h, input logic [31:0] l,
                     input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rst = r;
    bus.wb_wreg = w; bus.wb_wd = wd; bus.wb_wdata = wdata;
    bus.wb_whilo = hl; bus.wb_hi = h; bus.wb_lo = l;
    bus.re1 = e1; bus.raddr1 = a1; bus.re2 = e2; bus.raddr2 = a2;
  endtask

  // Check all outputs against the model, take one clock edge, commit into the model.
  task automatic step();
    #1;
    check("rdata1", bus.rdata1, exp_rd(bus.re1, bus.raddr1));
    check("rdata2", bus.rdata2, exp_rd(bus.re2, bus.raddr2));
    check("hi_o", bus.hi_o, rst ? 32'h0 : (bus.wb_whilo ? bus.wb_hi : ref_hi));
    check("lo_o", bus.lo_o, rst ? 32'h0 : (bus.wb_whilo ? bus.wb_lo : ref_lo));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
      ref_hi = 32'h0;
      ref_lo = 32'h0;
    end else begin
      if (bus.wb_wreg && bus.wb_wd != 5'd0) ref_gpr[bus.wb_wd] = bus.wb_wdata;
      if (bus.wb_whilo) begin
        ref_hi = bus.wb_hi;
        ref_lo = bus.wb_lo;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] wd;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
    ref_hi = 32'h0;
    ref_lo = 32'h0;

    // Reset with the upstream reset bundle (write enable, address 0, all-ones data).
    drv(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 5'd3, 1, 5'd0);
    @(negedge clk);
    step();
    step();
    for (int a = 0; a < 32; a++) begin
      drv(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'(a), 1, 5'(31 - a));
      #1;
      check("rst_all_p1", bus.rdata1, 32'h0);
      check("rst_all_p2", bus.rdata2, 32'h0);
      check("rst_hi", bus.hi_o, 32'h0);
      check("rst_lo", bus.lo_o, 32'h0);
      step();
    end

    // Bypass then storage read of r5.
    drv(0, 1, 5'd5, 32'h1234_5678, 0, 32'h0, 32'h0, 1, 5'd5, 0, 5'd0);
    #1; check("r5_bypass", bus.rdata1, 32'h1234_5678);
    step();
    drv(0, 0, 5'd5, 32'h0, 0, 32'h0, 32'h0, 1, 5'd5, 0, 5'd0);
    #1; check("r5_stored", bus.rdata1, 32'h1234_5678);
    step();

    // r0 stays zero.
    drv(0, 1, 5'd0, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 1, 5'd0, 1, 5'd0);
    #1; check("r0_same_p1", bus.rdata1, 32'h0); check("r0_same_p2", bus.rdata2, 32'h0);
    step();
    drv(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd0, 1, 5'd0);
    #1; check("r0_next_p1", bus.rdata1, 32'h0); check("r0_next_p2", bus.rdata2, 32'h0);
    step();

    // Back-to-back writes to r7: bypass beats stored value; disabled port reads 0.
    drv(0, 1, 5'd7, 32'hA, 0, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0);
    step();
    drv(0, 1, 5'd7, 32'hB, 0, 32'h0, 32'h0, 1, 5'd7, 1, 5'd7);
    #1; check("r7_byp_p1", bus.rdata1, 32'hB); check("r7_byp_p2", bus.rdata2, 32'hB);
    step();
    drv(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd7, 0, 5'd7);
    #1; check("r7_stored", bus.rdata1, 32'hB); check("r7_re2_off", bus.rdata2, 32'h0);
    step();

    // Simultaneous HI/LO and GPR commit.
    drv(0, 1, 5'd31, 32'h3, 1, 32'h1, 32'h2, 0, 5'd0, 0, 5'd0);
    #1; check("hi_byp", bus.hi_o, 32'h1); check("lo_byp", bus.lo_o, 32'h2);
    step();
    drv(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd31, 1, 5'd7);
    #1;
    check("hi_stored", bus.hi_o, 32'h1); check("lo_stored", bus.lo_o, 32'h2);
    check("r31_stored", bus.rdata1, 32'h3); check("r7_kept", bus.rdata2, 32'hB);
    step();

    // A write on the reset edge is lost, and the earlier value is cleared.
    drv(0, 1, 5'd9, 32'h55, 0, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0);
    step();
    drv(1, 1, 5'd9, 32'h66, 1, 32'h7, 32'h8, 1, 5'd9, 1, 5'd9);
    #1; check("rst_forced_p1", bus.rdata1, 32'h0); check("rst_forced_hi", bus.hi_o, 32'h0);
    step();
    drv(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd9, 1, 5'd31);
    #1;
    check("r9_cleared", bus.rdata1, 32'h0); check("r31_cleared", bus.rdata2, 32'h0);
    check("hi_cleared", bus.hi_o, 32'h0); check("lo_cleared", bus.lo_o, 32'h0);
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      wd = 5'($urandom_range(0, 31));
      drv(($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)), wd, $urandom,
          ($urandom_range(0, 3) == 0), $urandom, $urandom,
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) == 0) ? wd : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) == 0) ? wd : 5'($urandom_range(0, 31)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
